// File: rtl/unidad_mult_div_if.sv
// Operand/result bundle for unidad_mult_div: start/op/operands in, HI/LO and status out.
// No flow control beyond start (sampled only when idle) and the busy/done handshake.
interface unidad_mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             exc;

  modport master (output start, op, op_a, op_b, input hi, lo, busy, done, exc);
  modport slave  (input start, op, op_a, op_b, output hi, lo, busy, done, exc);
endinterface

// File: rtl/unidad_mult_div.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU into HI/LO; start->done 34 cycles, one op per 35 cycles.
// start is sampled only in IDLE and ignored while busy; divide path present only with MULDIV_DIV_EN.
module unidad_mult_div #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  unidad_mult_div_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_div;
  logic                 r_sa;
  logic                 r_sb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opd;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]     r_a;
  logic                 r_exc;
`endif

  logic                 w_accept;
  logic                 w_sgn_in;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign w_accept = (r_state == S_IDLE) && mdu.start;
  assign w_sgn_in = ~mdu.op[0];
  assign w_abs_a  = (w_sgn_in && mdu.op_a[WIDTH-1]) ? -mdu.op_a : mdu.op_a;
  assign w_abs_b  = (w_sgn_in && mdu.op_b[WIDTH-1]) ? -mdu.op_b : mdu.op_b;

  // Multiply: conditional add into the upper half, carry kept in bit WIDTH, then shift right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_new;
  logic             w_ge;

  // Divide: {rem, quo} shifted left; the shifted remainder needs one extra bit for the compare.
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = w_rem_sh >= {1'b0, r_opd};
  assign w_rem_new = w_ge ? (w_rem_sh[WIDTH-1:0] - r_opd) : w_rem_sh[WIDTH-1:0];
  assign w_step    = r_div ? {w_rem_new, r_acc[WIDTH-2:0], w_ge} : w_mul_nxt;

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_exc) begin
        w_fix_hi = r_a;
        w_fix_lo = '1;
      end else begin
        w_fix_lo = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_fix_hi = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end
`else
  assign w_step   = w_mul_nxt;
  assign w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = w_prod[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mdu.start) begin
`ifdef MULDIV_DIV_EN
          w_state_nxt = S_CALC;
`else
          w_state_nxt = mdu.op[1] ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mdu.busy = 1'b0;
    mdu.done = 1'b0;
    mdu.exc  = 1'b0;
    case (r_state)
      S_CALC, S_FIX: mdu.busy = 1'b1;
      S_DONE: begin
        mdu.done = 1'b1;
`ifdef MULDIV_DIV_EN
        mdu.busy = 1'b1;
        mdu.exc  = r_exc;
`else
        mdu.busy = ~r_div;
        mdu.exc  = r_div;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_acc <= '0;
      r_opd <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
`ifdef MULDIV_DIV_EN
      r_a   <= '0;
      r_exc <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt <= '0;
        r_div <= mdu.op[1];
        r_sa  <= w_sgn_in & mdu.op_a[WIDTH-1];
        r_sb  <= w_sgn_in & mdu.op_b[WIDTH-1];
        r_acc <= {{WIDTH{1'b0}}, (mdu.op[1] ? w_abs_a : w_abs_b)};
        r_opd <= mdu.op[1] ? w_abs_b : w_abs_a;
`ifdef MULDIV_DIV_EN
        r_a   <= mdu.op_a;
        r_exc <= mdu.op[1] && (mdu.op_b == '0);
`endif
      end else if (r_state == S_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_FIX) begin
        r_hi <= w_fix_hi;
        r_lo <= w_fix_lo;
      end
    end
  end

  assign mdu.hi = r_hi;
  assign mdu.lo = r_lo;
endmodule

// File: tb/tb_unidad_mult_div.sv
// Bench for unidad_mult_div: timeline/arithmetic reference model checked every cycle plus literal result checks.
module tb_unidad_mult_div;
  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  unidad_mult_div_if #(.WIDTH(32)) bus ();
  unidad_mult_div #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .mdu(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic ex);
    longint sa, sb, q, r;
    logic [63:0] p;
    ex = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          ex = 1'b1;
          p = {a, 32'hFFFFFFFF};
        end else if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return p;
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  logic        m_pexc, m_unsup;
  int          m_left;

  // m_left = cycles remaining until and including the done cycle
  always @(posedge clk) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_unsup = 1'b0; m_pexc = 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_pend = ref_calc(bus.op, bus.op_a, bus.op_b, m_pexc);
`ifdef MULDIV_DIV_EN
        m_unsup = 1'b0;
        m_left  = 34;
`else
        m_unsup = bus.op[1];
        m_left  = bus.op[1] ? 1 : 34;
        if (bus.op[1]) m_pexc = 1'b1;
`endif
      end
    end else begin
      m_left--;
      if (m_left == 1 && !m_unsup) {m_hi, m_lo} = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
      chk("cyc_busy", 32'(bus.busy), 32'(m_left != 0 && !m_unsup));
      chk("cyc_done", 32'(bus.done), 32'(m_left == 1));
      chk("cyc_exc", 32'(bus.exc), 32'(m_left == 1 && m_pexc));
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic eexc);
    int n;
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
    chk({name, "_exc"}, 32'(bus.exc), 32'(eexc));
    @(negedge clk);
  endtask

  initial begin
    int  n;
    logic saw_done;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult", 2'b00, 32'd7, 32'hFFFFFFFD, 34, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_nn", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 34, 32'h0, 32'd30, 1'b0);
    run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h0, 1'b0);
`ifdef MULDIV_DIV_EN
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0);
    run_op("div_pn", 2'b10, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op("divu", 2'b11, 32'hFFFFFFFF, 32'd10, 34, 32'd5, 32'h19999999, 1'b0);
    run_op("divu_z", 2'b11, 32'd100, 32'd0, 34, 32'h00000064, 32'hFFFFFFFF, 1'b1);
    run_op("div_z", 2'b10, 32'hFFFFFFFB, 32'd0, 34, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
`else
    run_op("divu_off", 2'b11, 32'd100, 32'd0, 1, 32'h40000000, 32'h0, 1'b1);
    run_op("div_off", 2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'h40000000, 32'h0, 1'b1);
`endif

    // start while busy is ignored; start held through DONE is taken one cycle later
    bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    n++;
    bus.start = 1'b0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 32'(n), 32'd34);
    chk("ign_lo", bus.lo, 32'd15);
    chk("ign_hi", bus.hi, 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    chk("ign_idle35", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_acc35", 32'(bus.busy), 32'd1);
    n = 1;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("acc35_lat", 32'(n), 32'd34);
    chk("acc35_lo", bus.lo, 32'd81);
    @(negedge clk);

    // reset mid-operation aborts without done
`ifdef MULDIV_DIV_EN
    bus.op = 2'b11;
`else
    bus.op = 2'b01;
`endif
    bus.start = 1'b1; bus.op_a = 32'd50; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_nodone", 32'(saw_done), 32'd0);
`ifdef MULDIV_DIV_EN
    run_op("divu_50_7", 2'b11, 32'd50, 32'd7, 34, 32'd1, 32'd7, 1'b0);
`else
    run_op("multu_50_7", 2'b01, 32'd50, 32'd7, 34, 32'd0, 32'd350, 1'b0);
`endif

    // reset and start together: reset wins
    rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.op_a = 32'd2; bus.op_b = 32'd3;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start_busy", 32'(bus.busy), 32'd0);
    chk("rst_start_lo", bus.lo, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_start_idle", 32'(bus.busy), 32'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
